// File: rtl/imm_encoder_writer_pkg.sv
// Shared types for the immediate extender/encoder pair.
// Immediate format codes, FSM states and instruction field positions.
package imm_encoder_writer_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } immsrc_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READY = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam int OPC_LSB = 0;
  localparam int RD_LSB  = 7;
  localparam int F3_LSB  = 12;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int F7_LSB  = 25;

endpackage

// File: rtl/imm_encoder_writer_if.sv
// Request/write bundle of the immediate encoder-writer.
// master = program loader side, slave = encoder-writer side.
interface imm_encoder_writer_if #(
  parameter int XLEN = 32,
  parameter int AW   = 10
);

  logic            start;
  logic [AW-1:0]   base_addr;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_immsrc;
  logic [XLEN-1:0] in_imm;
  logic [31:0]     in_instr;
  logic            wr_en;
  logic            wr_ready;
  logic [AW-1:0]   wr_addr;
  logic [31:0]     wr_data;
  logic            err;
  logic [7:0]      err_count;
  logic            busy;

  modport master (
    output start, base_addr,
    output in_valid, in_immsrc,
    output in_imm, in_instr,
    output wr_ready,
    input  in_ready, wr_en,
    input  wr_addr, wr_data,
    input  err, err_count, busy
  );

  modport slave (
    input  start, base_addr,
    input  in_valid, in_immsrc,
    input  in_imm, in_instr,
    input  wr_ready,
    output in_ready, wr_en,
    output wr_addr, wr_data,
    output err, err_count, busy
  );

endinterface

// File: rtl/imm_encoder_writer_imm_pack.sv
// Combinational packer: places an immediate into a template.
// Ports: immsrc_i, imm_i, instr_i in; instr_o, legal_o out.
module imm_pack
  import imm_encoder_writer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      immsrc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [31:0]     instr_i,
  output logic [31:0]     instr_o,
  output logic            legal_o
);

  logic signed [XLEN-1:0] simm;
  logic [XLEN-1:0] up11;
  logic [XLEN-1:0] up12;
  logic [XLEN-1:0] up20;
  logic [XLEN-1:0] up31;
  logic ok11, ok12, ok20, ok31;

  // An arithmetic shift by n leaves all ones/zeros
  // exactly when imm[XLEN-1:n] are all equal.
  assign simm = imm_i;
  assign up11 = simm >>> 11;
  assign up12 = simm >>> 12;
  assign up20 = simm >>> 20;
  assign up31 = simm >>> 31;
  assign ok11 = (up11 == '0) || (up11 == '1);
  assign ok12 = (up12 == '0) || (up12 == '1);
  assign ok20 = (up20 == '0) || (up20 == '1);
  assign ok31 = (up31 == '0) || (up31 == '1);

  always_comb begin
    instr_o = instr_i;
    legal_o = 1'b0;
    case (immsrc_i)
      IMM_I: begin
        instr_o = {imm_i[11:0],
                   instr_i[RS2_LSB-1:0]};
        legal_o = ok11;
      end
      IMM_S: begin
        instr_o = {imm_i[11:5],
                   instr_i[F7_LSB-1:RD_LSB+5],
                   imm_i[4:0],
                   instr_i[RD_LSB-1:OPC_LSB]};
        legal_o = ok11;
      end
      IMM_B: begin
        instr_o = {imm_i[12], imm_i[10:5],
                   instr_i[F7_LSB-1:RD_LSB+5],
                   imm_i[4:1], imm_i[11],
                   instr_i[RD_LSB-1:OPC_LSB]};
        legal_o = ok12 && !imm_i[0];
      end
      IMM_J: begin
        instr_o = {imm_i[20], imm_i[10:1],
                   imm_i[11], imm_i[19:12],
                   instr_i[F3_LSB-1:OPC_LSB]};
        legal_o = ok20 && !imm_i[0];
      end
      IMM_U: begin
        instr_o = {imm_i[31:12],
                   instr_i[F3_LSB-1:OPC_LSB]};
        legal_o = (imm_i[11:0] == 12'd0) && ok31;
      end
      default: begin
        instr_o = instr_i;
        legal_o = 1'b0;
      end
    endcase
  end

  logic unused_ok;
  assign unused_ok = ^{RS1_LSB};

endmodule

// File: rtl/imm_encoder_writer.sv
// Encodes immediates into templates and streams them to imem.
// Ports: clk, reset, bus (request in, write port, error status).
module imm_encoder_writer
  import imm_encoder_writer_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int AW   = 10
) (
  input logic             clk,
  input logic             reset,
  imm_encoder_writer_if.slave bus
);

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [31:0]     data_q, data_d;
  logic            err_q, err_d;
  logic [7:0]      cnt_q, cnt_d;

  logic [31:0]     pk_data;
  logic            pk_legal;
  logic            accept;
  logic            wdone;
  logic            rdy;

  imm_pack #(.XLEN(XLEN)) u_pack (
    .immsrc_i (bus.in_immsrc),
    .imm_i    (bus.in_imm),
    .instr_i  (bus.in_instr),
    .instr_o  (pk_data),
    .legal_o  (pk_legal)
  );

  assign rdy    = (state_q == ST_READY) && !bus.start;
  assign accept = rdy && bus.in_valid;
  assign wdone  = (state_q == ST_HOLD) && bus.wr_ready;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.start) begin
      state_d = ST_READY;
    end else begin
      unique case (state_q)
        ST_IDLE:  state_d = ST_IDLE;
        ST_READY: if (accept && pk_legal)
                    state_d = ST_HOLD;
        ST_HOLD:  if (bus.wr_ready)
                    state_d = ST_READY;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.in_ready = rdy;
    bus.wr_en    = (state_q == ST_HOLD);
    bus.busy     = (state_q == ST_HOLD);
  end

  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    err_d  = err_q;
    cnt_d  = cnt_q;
    if (bus.start) begin
      addr_d = bus.base_addr;
      err_d  = 1'b0;
      cnt_d  = 8'd0;
    end else begin
      if (accept && pk_legal)
        data_d = pk_data;
      if (accept && !pk_legal) begin
        err_d = 1'b1;
        if (cnt_q != 8'hFF)
          cnt_d = cnt_q + 8'd1;
      end
      // Address wraps naturally at 2**AW.
      if (wdone)
        addr_d = addr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
      cnt_q  <= 8'd0;
    end else begin
      addr_q <= addr_d;
      data_q <= data_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.wr_addr   = addr_q;
  assign bus.wr_data   = data_q;
  assign bus.err       = err_q;
  assign bus.err_count = cnt_q;

endmodule

// File: tb/tb_imm_encoder_writer.sv
// Scoreboard bench for imm_encoder_writer.
// Directed vectors; monitor checks every completed write.
module tb_imm_encoder_writer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  logic [9:0] exp_addr = '0;

  typedef struct {
    logic [9:0]  a;
    logic [31:0] d;
  } exp_t;
  exp_t sb[$];

  imm_encoder_writer_if #(.XLEN(32), .AW(10)) bus ();

  imm_encoder_writer #(.XLEN(32), .AW(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && bus.wr_en && bus.wr_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: addr %h data %h",
                 bus.wr_addr, bus.wr_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wr_addr", {22'd0, bus.wr_addr}, {22'd0, e.a});
        chk("wr_data", bus.wr_data, e.d);
      end
    end
  end

  task automatic send(input logic [2:0] src,
                      input logic [31:0] imm,
                      input logic [31:0] ins,
                      input logic [31:0] expd,
                      input bit legal,
                      input bit push);
    bit got;
    @(posedge clk); #1;
    bus.in_valid  = 1'b1;
    bus.in_immsrc = src;
    bus.in_imm    = imm;
    bus.in_instr  = ins;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.in_ready) got = 1'b1;
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: in_ready %b expected 1",
               bus.in_ready);
    end else if (legal && push) begin
      sb.push_back('{exp_addr, expd});
      exp_addr = exp_addr + 10'd1;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic do_start(input logic [9:0] b);
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.base_addr = b;
    @(negedge clk);
    chk("in_ready_start", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    exp_addr  = b;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.wr_en) done = 1'b1;
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: pending %0d expected 0",
               sb.size());
    end
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.in_valid  = 1'b0;
    bus.in_immsrc = 3'd0;
    bus.in_imm    = '0;
    bus.in_instr  = '0;
    bus.wr_ready  = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_en", {31'd0, bus.wr_en}, 32'd0);
    chk("rst_wr_addr", {22'd0, bus.wr_addr}, 32'd0);
    chk("rst_wr_data", bus.wr_data, 32'd0);
    chk("rst_err", {31'd0, bus.err}, 32'd0);
    chk("rst_err_count", {24'd0, bus.err_count}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", {31'd0, bus.in_ready}, 32'd0);

    // Legal encodes, one per format
    do_start(10'h010);
    send(3'b000, 32'hFFFFFFFF, 32'h00000093,
         32'hFFF00093, 1'b1, 1'b1);
    send(3'b000, 32'h00000001, 32'h00000013,
         32'h00100013, 1'b1, 1'b1);
    send(3'b001, 32'h00000008, 32'h0020A023,
         32'h0020A423, 1'b1, 1'b1);
    send(3'b010, 32'hFFFFFFFC, 32'h00000063,
         32'hFE000EE3, 1'b1, 1'b1);
    send(3'b011, 32'h00000800, 32'h000000EF,
         32'h001000EF, 1'b1, 1'b1);
    send(3'b100, 32'h12345000, 32'h000002B7,
         32'h123452B7, 1'b1, 1'b1);
    drain();

    // Rejected immediates
    send(3'b000, 32'h00000800, 32'h00000093,
         32'h0, 1'b0, 1'b0);
    send(3'b010, 32'h00000003, 32'h00000063,
         32'h0, 1'b0, 1'b0);
    send(3'b100, 32'h00001001, 32'h000002B7,
         32'h0, 1'b0, 1'b0);
    send(3'b111, 32'h00000000, 32'h00000013,
         32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("ill_err", {31'd0, bus.err}, 32'd1);
    chk("ill_err_count", {24'd0, bus.err_count}, 32'd4);
    chk("ill_wr_addr", {22'd0, bus.wr_addr}, 32'h016);
    chk("ill_wr_en", {31'd0, bus.wr_en}, 32'd0);
    do_start(10'h020);
    @(negedge clk);
    chk("clr_err", {31'd0, bus.err}, 32'd0);
    chk("clr_err_count", {24'd0, bus.err_count}, 32'd0);
    chk("clr_wr_addr", {22'd0, bus.wr_addr}, 32'h020);

    // Back-pressure: 3 stalled cycles, done on 4th
    bus.wr_ready = 1'b0;
    send(3'b000, 32'h00000005, 32'h00000013,
         32'h00500013, 1'b1, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("stall_wr_en", {31'd0, bus.wr_en}, 32'd1);
      chk("stall_wr_addr", {22'd0, bus.wr_addr}, 32'h020);
      chk("stall_wr_data", bus.wr_data, 32'h00500013);
      chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("stall_busy", {31'd0, bus.busy}, 32'd1);
    end
    @(posedge clk); #1;
    bus.wr_ready = 1'b1;
    drain();
    chk("post_stall_addr", {22'd0, bus.wr_addr}, 32'h021);

    // Address wrap
    do_start(10'h3FF);
    send(3'b000, 32'h00000007, 32'h00000013,
         32'h00700013, 1'b1, 1'b1);
    send(3'b000, 32'hFFFFF800, 32'h00000013,
         32'h80000013, 1'b1, 1'b1);
    drain();
    chk("wrap_wr_addr", {22'd0, bus.wr_addr}, 32'h001);

    // start with in_valid in READY: request ignored
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.base_addr = 10'h100;
    bus.in_valid  = 1'b1;
    bus.in_immsrc = 3'b000;
    bus.in_imm    = 32'h1;
    bus.in_instr  = 32'h13;
    @(negedge clk);
    chk("coinc_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    exp_addr     = 10'h100;
    @(negedge clk);
    chk("coinc_wr_en", {31'd0, bus.wr_en}, 32'd0);
    chk("coinc_wr_addr", {22'd0, bus.wr_addr}, 32'h100);
    chk("coinc_in_ready2", {31'd0, bus.in_ready}, 32'd1);

    // Reset while a write is pending
    bus.wr_ready = 1'b0;
    send(3'b000, 32'h00000009, 32'h00000013,
         32'h00900013, 1'b1, 1'b0);
    reset = 1'b1;
    bus.wr_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rh_wr_en", {31'd0, bus.wr_en}, 32'd0);
    chk("rh_busy", {31'd0, bus.busy}, 32'd0);
    chk("rh_wr_addr", {22'd0, bus.wr_addr}, 32'h000);
    repeat (3) @(negedge clk);
    chk("rh_in_ready", {31'd0, bus.in_ready}, 32'd0);
    do_start(10'h005);
    send(3'b100, 32'hFFFFF000, 32'h00000037,
         32'hFFFFF037, 1'b1, 1'b1);
    drain();

    chk("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: time %0t limit 200000",
             $time);
    $fatal(1);
  end

endmodule
